// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator: per-channel period register, down-counter
// and IDLE/RUN/DONE sequencer producing single-cycle tick pulses.
module game_tick_gen #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 10_000_000,
  parameter int MIN_PERIOD     = 2,
  parameter int STEP           = 1
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                                 cfg_period,
  input  logic [CHANNELS-1:0]                              ch_en,
  input  logic [CHANNELS-1:0]                              ch_oneshot,
  input  logic                                             pause,
  input  logic [CHANNELS-1:0]                              speed_up,
  output logic [CHANNELS-1:0]                              tick,
  output logic [CHANNELS-1:0]                              running,
  output logic [CHANNELS*WIDTH-1:0]                        period_o
);

  localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] RESET_P = (DEFAULT_PERIOD > MIN_PERIOD) ?
                                         WIDTH'(DEFAULT_PERIOD) : WIDTH'(MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [WIDTH-1:0]    cnt_d   [CHANNELS];
  logic [WIDTH-1:0]    per_q   [CHANNELS];
  logic [WIDTH-1:0]    per_d   [CHANNELS];
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;

  // Clamp a written period to the lower bound.
  function automatic logic [WIDTH-1:0] sat_write(input logic [WIDTH-1:0] p);
    if (p < MIN_P) sat_write = MIN_P;
    else           sat_write = p;
  endfunction

  // Decrement by STEP, evaluated one bit wider so the floor test cannot wrap.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] floor_v;
    floor_v = {1'b0, MIN_P} + (WIDTH+1)'(STEP);
    if ({1'b0, p} >= floor_v) sat_dec = p - WIDTH'(STEP);
    else                      sat_dec = MIN_P;
  endfunction

  // Next-state: sequencer, counter and period update per channel
  always_comb begin
    tick_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      per_d[i]   = per_q[i];

      if (!ch_en[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (!pause) begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i] = RUN;
            cnt_d[i]   = per_q[i] - WIDTH'(1);
          end
          RUN: begin
            if (cnt_q[i] == '0) begin
              tick_d[i] = 1'b1;
              if (ch_oneshot[i]) begin
                state_d[i] = DONE;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = per_q[i] - WIDTH'(1);
              end
            end else begin
              cnt_d[i] = cnt_q[i] - WIDTH'(1);
            end
          end
          DONE: begin
            state_d[i] = DONE;
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end

      // A configuration write outranks a same-cycle speed-up on that channel.
      if (cfg_we && (int'(cfg_ch) == i)) begin
        per_d[i] = sat_write(cfg_period);
      end else if (speed_up[i]) begin
        per_d[i] = sat_dec(per_q[i]);
      end
    end
  end

  // Register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        per_q[i]   <= RESET_P;
      end
    end else begin
      tick_q <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        per_q[i]   <= per_d[i];
      end
    end
  end

  always_comb begin
    tick     = tick_q;
    running  = '0;
    period_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      running[i]                 = (state_q[i] == RUN);
      period_o[i*WIDTH +: WIDTH] = per_q[i];
    end
  end

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed testbench for game_tick_gen: three channels, 16-bit periods, default period 20.
module tb_game_tick_gen;

  localparam int CH   = 3;
  localparam int W    = 16;
  localparam int DEF  = 20;
  localparam int MINP = 2;
  localparam int STP  = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [W-1:0]      cfg_period;
  logic [CH-1:0]     ch_en;
  logic [CH-1:0]     ch_oneshot;
  logic              pause;
  logic [CH-1:0]     speed_up;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     running;
  logic [CH*W-1:0]   period_o;

  int tests_run    = 0;
  int tests_failed = 0;

  game_tick_gen #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(DEF), .MIN_PERIOD(MINP), .STEP(STP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .ch_en(ch_en), .ch_oneshot(ch_oneshot),
    .pause(pause), .speed_up(speed_up), .tick(tick), .running(running),
    .period_o(period_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] per(input int c);
    return period_o[c*W +: W];
  endfunction

  task automatic test_reset();
    tests_run++;
    if (tick !== 3'b000 || running !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: tick=%b running=%b, required 000/000", tick, running);
    end
    for (int c = 0; c < CH; c++) begin
      tests_run++;
      if (per(c) !== W'(DEF)) begin
        tests_failed++;
        $display("FAIL reset_period ch%0d: got %0d, required %0d", c, per(c), DEF);
      end
    end
  endtask

  task automatic test_periodic();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = W'(4);
    step();
    cfg_we = 1'b0;
    tests_run++;
    if (per(0) !== W'(4)) begin
      tests_failed++;
      $display("FAIL periodic_write: period_o ch0=%0d, required 4", per(0));
    end
    ch_en[0] = 1'b1;
    step();
    tests_run++;
    if (running[0] !== 1'b1 || tick[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL periodic_enter: running=%b tick=%b, required 1/0", running[0], tick[0]);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (tick[0] !== 1'((k % 4) == 0) || running[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL periodic_tick k=%0d: tick=%b running=%b, required %b/1",
                 k, tick[0], running[0], 1'((k % 4) == 0));
      end
    end
    ch_en[0] = 1'b0;
    step();
    tests_run++;
    if (running[0] !== 1'b0 || tick[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL periodic_disable: running=%b tick=%b, required 0/0", running[0], tick[0]);
    end
  endtask

  task automatic test_oneshot();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = W'(3);
    step();
    cfg_we = 1'b0;
    ch_oneshot[0] = 1'b1;
    ch_en[0] = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (tick[0] !== 1'(k == 3) || running[0] !== 1'(k < 3)) begin
        tests_failed++;
        $display("FAIL oneshot k=%0d: tick=%b running=%b, required %b/%b",
                 k, tick[0], running[0], 1'(k == 3), 1'(k < 3));
      end
    end
    ch_en[0] = 1'b0;
    step();
    ch_en[0] = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (tick[0] !== 1'(k == 3)) begin
        tests_failed++;
        $display("FAIL oneshot_rearm k=%0d: tick=%b, required %b", k, tick[0], 1'(k == 3));
      end
    end
    ch_en[0] = 1'b0;
    ch_oneshot[0] = 1'b0;
    step();
  endtask

  task automatic test_pause();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = W'(4);
    step();
    cfg_we = 1'b0;
    ch_en[0] = 1'b1;
    step();
    step();
    pause = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (tick[0] !== 1'b0 || running[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL pause_hold k=%0d: tick=%b running=%b, required 0/1", k, tick[0], running[0]);
      end
    end
    pause = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      tests_run++;
      if (tick[0] !== 1'(k == 3 || k == 7)) begin
        tests_failed++;
        $display("FAIL pause_resume k=%0d: tick=%b, required %b", k, tick[0], 1'(k == 3 || k == 7));
      end
    end
    ch_en[0] = 1'b0;
    step();
  endtask

  task automatic test_speed_up();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = W'(10);
    step();
    cfg_we = 1'b0;
    speed_up[0] = 1'b1;
    step();
    speed_up[0] = 1'b0;
    tests_run++;
    if (per(0) !== W'(9)) begin
      tests_failed++;
      $display("FAIL speed_up_dec: period_o ch0=%0d, required 9", per(0));
    end
    cfg_we = 1'b1; cfg_period = W'(3);
    step();
    cfg_we = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      speed_up[0] = 1'b1;
      step();
      speed_up[0] = 1'b0;
      tests_run++;
      if (per(0) !== W'(2)) begin
        tests_failed++;
        $display("FAIL speed_up_floor n=%0d: period_o ch0=%0d, required 2", n, per(0));
      end
    end
    cfg_we = 1'b1; cfg_period = W'(0);
    step();
    cfg_we = 1'b0;
    tests_run++;
    if (per(0) !== W'(2)) begin
      tests_failed++;
      $display("FAIL write_zero: period_o ch0=%0d, required 2", per(0));
    end
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = W'(5);
    step();
    cfg_we = 1'b0;
    tests_run++;
    if (per(0) !== W'(2) || per(1) !== W'(DEF) || per(2) !== W'(DEF)) begin
      tests_failed++;
      $display("FAIL write_out_of_range: periods=%0d/%0d/%0d, required 2/%0d/%0d",
               per(0), per(1), per(2), DEF, DEF);
    end
    pause = 1'b1;
    speed_up[2] = 1'b1;
    step();
    speed_up[2] = 1'b0;
    pause = 1'b0;
    tests_run++;
    if (per(2) !== W'(DEF - 1)) begin
      tests_failed++;
      $display("FAIL speed_up_paused: period_o ch2=%0d, required %0d", per(2), DEF - 1);
    end
  endtask

  task automatic test_back_to_back();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = W'(8);
    speed_up[1] = 1'b1;
    step();
    cfg_we = 1'b0;
    speed_up[1] = 1'b0;
    tests_run++;
    if (per(1) !== W'(8)) begin
      tests_failed++;
      $display("FAIL cfg_beats_speed_up: period_o ch1=%0d, required 8", per(1));
    end
    ch_en[1:0] = 2'b11;
    step();
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = W'(6);
      end else begin
        cfg_we = 1'b0;
      end
      step();
      tests_run++;
      if (tick[1:0] !== {1'(k == 8 || k == 14 || k == 20), 1'((k % 2) == 0)}) begin
        tests_failed++;
        $display("FAIL two_channel k=%0d: tick=%b, required %b%b", k, tick[1:0],
                 1'(k == 8 || k == 14 || k == 20), 1'((k % 2) == 0));
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_midcount();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (tick !== 3'b000 || running !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: tick=%b running=%b, required 000/000", tick, running);
    end
    for (int c = 0; c < CH; c++) begin
      tests_run++;
      if (per(c) !== W'(DEF)) begin
        tests_failed++;
        $display("FAIL reset_mid_period ch%0d: got %0d, required %0d", c, per(c), DEF);
      end
    end
    #3;
    reset_n = 1'b1;
    step();
    tests_run++;
    if (tick !== 3'b000 || running[1:0] !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_release: tick=%b running=%b, required 000/x11", tick, running);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    ch_en = '0; ch_oneshot = '0; pause = 1'b0; speed_up = '0;
    #12;
    test_reset();
    reset_n = 1'b1;
    step();
    test_periodic();
    test_oneshot();
    test_pause();
    test_speed_up();
    test_back_to_back();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
